// File: rtl/histo_pkg.sv
// histo_pkg: shared sizes and sequencer states for the histogram RAM controller.
package histo_pkg;

  localparam int HISTO_ADDR_W = 10;
  localparam int HISTO_DATA_W = 24;
  localparam int NUM_BINS     = 2 ** HISTO_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    READOUT
  } histo_state_e;

endpackage

// File: rtl/histo_skid_buf.sv
// histo_skid_buf: 2-entry valid/ready buffer for readout beats {bin, data, last}.
// The producer only pushes when a slot is guaranteed, so there is no in_ready.
module histo_skid_buf #(
  parameter int W = 35
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] slot_q [2];
  logic [W-1:0] slot_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  assign pop         = (count_q != 2'd0) && out_ready_i;
  assign push        = in_valid_i && ((count_q != 2'd2) || pop);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = slot_q[rd_ptr_q];
  assign count_o     = count_q;

  // Head slot only moves on a pop, so the output holds while stalled.
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      slot_d[wr_ptr_q] = in_data_i;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  // Buffer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      slot_q    <= slot_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/histo_ram_ctrl.sv
// histo_ram_ctrl: per-frame sequencer for the dual-port histogram RAM.
// Optional macro HISTO_SAT_EN: bins saturate at all-ones instead of wrapping.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | writing 0 to every bin, one per cycle
// ACCUM   | read-modify-write increment per hit
// DRAIN   | waiting for the last RMW write to land
// READOUT | streaming bins out, clearing each accepted bin
module histo_ram_ctrl
  import histo_pkg::*;
#(
  parameter int ADDR_W = HISTO_ADDR_W,
  parameter int DATA_W = HISTO_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic              frame_end,
  input  logic              hit_valid,
  input  logic [ADDR_W-1:0] hit_bin,
  output logic              busy,
  output logic              accum_ready,
  output logic [15:0]       dropped,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_bin,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_we
);

  localparam int BEAT_W = ADDR_W + DATA_W + 1;

  // The RMW timing and forwarding below assume Q arrives one cycle after the read.
  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("histo_ram_ctrl supports RD_LAT == 1 only");
  end

  histo_state_e      state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_pend_bin_q, rd_pend_bin_d;
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic [15:0]       dropped_q, dropped_d;

  logic [DATA_W-1:0] s1_base, s1_inc;
  logic              sb_valid, sb_pop, rd_go;
  logic [1:0]        sb_count;
  logic [2:0]        occ_next;
  logic [BEAT_W-1:0] sb_in, sb_out;

  assign busy        = (state_q != IDLE);
  assign accum_ready = (state_q == ACCUM);
  assign dropped     = dropped_q;

  // S1 increment. A read issued in the same cycle as the previous hit's write
  // returns the old value, so that write is forwarded in place of ram_q.
  always_comb begin
    s1_base = ((fwd_valid_q) && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : ram_q;
`ifdef HISTO_SAT_EN
    s1_inc = (&s1_base) ? s1_base : s1_base + DATA_W'(1);
`else
    s1_inc = s1_base + DATA_W'(1);
`endif
  end

  // Readout prefetch: read only if the skid buffer can take the data next cycle.
  assign sb_pop   = sb_valid && out_ready;
  assign occ_next = 3'(sb_count) + 3'(rd_pend_q) - 3'(sb_pop);
  assign rd_go    = (state_q == READOUT) && !rd_ptr_q[ADDR_W] && (occ_next < 3'd2);
  assign sb_in    = {rd_pend_bin_q, ram_q, &rd_pend_bin_q};

  histo_skid_buf #(.W(BEAT_W)) u_skid (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .in_valid_i  (rd_pend_q),
    .in_data_i   (sb_in),
    .out_valid_o (sb_valid),
    .out_ready_i (out_ready),
    .out_data_o  (sb_out),
    .count_o     (sb_count)
  );

  assign out_valid                    = sb_valid;
  assign {out_bin, out_data, out_last} = sb_valid ? sb_out : '0;

  // Next state and RAM port drive for each phase.
  always_comb begin
    state_d     = state_q;
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    ram_we      = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        ram_we      = 1'b1;
        ram_wr_addr = clr_addr_q;
        if (&clr_addr_q) state_d = ACCUM;
      end
      ACCUM: begin
        ram_rd_en = hit_valid;
        if (hit_valid) ram_rd_addr = hit_bin;
        if (frame_end) state_d = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid_q) state_d = READOUT;
      end
      READOUT: begin
        ram_rd_en = rd_go;
        if (rd_go) ram_rd_addr = rd_ptr_q[ADDR_W-1:0];
        ram_we = sb_pop;
        if (sb_pop) ram_wr_addr = out_bin;
        if (sb_pop && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (s1_valid_q) begin
      ram_we      = 1'b1;
      ram_wr_addr = s1_addr_q;
      ram_wr_data = s1_inc;
    end
  end

  // Counters, RMW pipeline and drop counter next values.
  always_comb begin
    clr_addr_d    = (state_q == CLEAR) ? clr_addr_q + ADDR_W'(1) : '0;
    rd_ptr_d      = (state_q != READOUT) ? '0 :
                    (rd_go ? rd_ptr_q + (ADDR_W+1)'(1) : rd_ptr_q);
    rd_pend_d     = rd_go;
    rd_pend_bin_d = rd_ptr_q[ADDR_W-1:0];
    s1_valid_d    = (state_q == ACCUM) && hit_valid;
    s1_addr_d     = hit_bin;
    fwd_valid_d   = s1_valid_q;
    fwd_addr_d    = s1_addr_q;
    fwd_data_d    = s1_inc;
    dropped_d     = dropped_q;
    if ((state_q == IDLE) && start) begin
      dropped_d = '0;
    end else if (hit_valid && (state_q != ACCUM) && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  // State and datapath registers; reset abandons any in-flight RMW.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      clr_addr_q    <= '0;
      rd_ptr_q      <= '0;
      rd_pend_q     <= 1'b0;
      rd_pend_bin_q <= '0;
      s1_valid_q    <= 1'b0;
      s1_addr_q     <= '0;
      fwd_valid_q   <= 1'b0;
      fwd_addr_q    <= '0;
      fwd_data_q    <= '0;
      dropped_q     <= '0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_pend_q     <= rd_pend_d;
      rd_pend_bin_q <= rd_pend_bin_d;
      s1_valid_q    <= s1_valid_d;
      s1_addr_q     <= s1_addr_d;
      fwd_valid_q   <= fwd_valid_d;
      fwd_addr_q    <= fwd_addr_d;
      fwd_data_q    <= fwd_data_d;
      dropped_q     <= dropped_d;
    end
  end

endmodule

// File: tb/tb_histo_ram_ctrl.sv
// tb_histo_ram_ctrl: randomized frames against a bin-count model, with a
// behavioural 1-cycle-latency RAM and a scoreboard on the readout stream.
module tb_histo_ram_ctrl;

  localparam int AW = 10;
  localparam int DW = 24;
  localparam int NB = 1024;
  localparam int unsigned MAXV = (1 << DW) - 1;

  typedef struct {
    logic [AW-1:0] bin;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic          frame_end = 1'b0;
  logic          hit_valid = 1'b0;
  logic [AW-1:0] hit_bin = '0;
  logic          out_ready = 1'b0;
  logic          busy, accum_ready, out_valid, out_last, ram_rd_en, ram_we;
  logic [15:0]   dropped;
  logic [AW-1:0] out_bin, ram_rd_addr, ram_wr_addr;
  logic [DW-1:0] out_data, ram_wr_data, ram_q;

  // Environment RAM with a bench-side preload port.
  logic [DW-1:0] mem [NB];
  logic [DW-1:0] q_r = '0;
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;

  int          n_chk = 0;
  int          n_fail = 0;
  int          beats_seen = 0;
  int          ready_mode = 0;
  int unsigned hist [NB];
  int unsigned mdrop = 0;
  beat_t       exp_q [$];

  histo_ram_ctrl dut (
    .Clock(Clock), .Reset(Reset), .start(start), .frame_end(frame_end),
    .hit_valid(hit_valid), .hit_bin(hit_bin), .busy(busy), .accum_ready(accum_ready),
    .dropped(dropped), .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_data(out_data), .out_last(out_last), .ram_rd_addr(ram_rd_addr),
    .ram_rd_en(ram_rd_en), .ram_q(ram_q), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_we(ram_we)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) q_r <= mem[ram_rd_addr];
  end
  assign ram_q = q_r;

  function automatic int unsigned bump(input int unsigned v);
`ifdef HISTO_SAT_EN
    return (v == MAXV) ? v : v + 1;
`else
    return (v + 1) % (MAXV + 1);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic hit_cycle(input logic v, input logic [AW-1:0] b);
    hit_valid = v;
    hit_bin   = b;
    if (v) begin
      if (accum_ready) hist[b] = bump(hist[b]);
      else if (mdrop < 32'hFFFF) mdrop++;
    end
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", {busy, accum_ready, out_valid, out_last, ram_we, ram_rd_en}, 0);
    check("rst_dropped", dropped, 0);
    check("rst_out_bus", {out_bin, out_data}, 0);
    check("rst_ram_bus", {ram_rd_addr, ram_wr_addr, ram_wr_data}, 0);
  endtask

  task automatic start_frame(input int drop_hits);
    int cnt, bad, cyc;
    start = 1'b1;
    mdrop = 0;
    tick();
    start = 1'b0;
    for (int i = 0; i < NB; i++) hist[i] = 0;
    check("dropped_clr_on_start", dropped, 0);
    cnt = 0; bad = 0; cyc = 0;
    while (!accum_ready && cyc < 1100) begin
      if (busy && ram_we && ram_wr_data == '0 && ram_wr_addr == AW'(cnt)) cnt++;
      else bad++;
      hit_valid = (cyc < drop_hits);
      hit_bin   = AW'(cyc * 37 + 5);
      if (hit_valid) mdrop++;
      tick();
      hit_valid = 1'b0;
      cyc++;
    end
    check("clear_writes", cnt, NB);
    check("clear_bad_cycles", bad, 0);
    check("accum_ready_after_clear", accum_ready, 1);
    check("dropped_after_clear", dropped, mdrop);
  endtask

  task automatic end_frame(input logic v, input logic [AW-1:0] b);
    frame_end = 1'b1;
    hit_valid = v;
    hit_bin   = b;
    if (v && accum_ready) hist[b] = bump(hist[b]);
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back('{bin: AW'(i), data: DW'(hist[i]), last: (i == NB - 1)});
      hist[i] = 0;
    end
    tick();
    frame_end = 1'b0;
    hit_valid = 1'b0;
  endtask

  task automatic wait_readout();
    int cyc, nz, b0;
    b0 = beats_seen;
    cyc = 0;
    while (busy && cyc < 60000) begin
      tick();
      cyc++;
    end
    check("readout_done", busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    check("beat_count", beats_seen - b0, NB);
    check("dropped_frame", dropped, mdrop);
    nz = 0;
    for (int i = 0; i < NB; i++) if (mem[i] != '0) nz++;
    check("ram_cleared_on_read", nz, 0);
  endtask

  // Readout consumer: always ready, or random with occasional long stalls.
  initial begin : ready_drv
    int low_cnt;
    low_cnt = 0;
    forever begin
      @(posedge Clock);
      #1;
      if (ready_mode == 0) begin
        out_ready = 1'b1;
      end else if (low_cnt > 0) begin
        out_ready = 1'b0;
        low_cnt--;
      end else if ($urandom_range(0, 15) == 0) begin
        out_ready = 1'b0;
        low_cnt = int'($urandom_range(5, 40));
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, checks stall stability.
  initial begin : monitor
    beat_t                b;
    logic                 stall_prev;
    logic [AW+DW:0]       prev_beat;
    stall_prev = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_hold", {out_valid, out_bin, out_data, out_last}, {1'b1, prev_beat});
        end
        if (out_valid && out_ready) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check("beat_bin", out_bin, b.bin);
            check("beat_data", out_data, b.data);
            check("beat_last", out_last, b.last);
          end
          beats_seen++;
        end
        stall_prev = out_valid && !out_ready;
        prev_beat  = {out_bin, out_data, out_last};
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, got busy=%0d, expected test end", busy);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [AW-1:0] rb;
    repeat (3) tick();
    Reset = 1'b0;
    check_reset_outputs();

    // Hits in IDLE are counted as dropped.
    hit_cycle(1'b1, AW'(11));
    hit_cycle(1'b1, AW'(12));
    check("dropped_idle", dropped, mdrop);

    // Frame 1: directed hazards, 3 hits during CLEAR.
    start_frame(3);
    repeat (4) hit_cycle(1'b1, AW'(5));
    hit_cycle(1'b0, '0);
    for (int i = 0; i < 8; i++) hit_cycle(1'b1, (i % 2 == 0) ? AW'(7) : AW'(8));
    hit_cycle(1'b1, AW'(3));
    hit_cycle(1'b0, '0);
    hit_cycle(1'b1, AW'(3));
    hit_cycle(1'b0, '0);
    end_frame(1'b0, '0);
    wait_readout();

    // Frame 2: random hits on a narrow bin range, random consumer stalls.
    ready_mode = 1;
    start_frame(0);
    for (int i = 0; i < 400; i++) begin
      rb = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NB - 1)) : AW'($urandom_range(0, 7));
      hit_cycle(1'($urandom_range(0, 3) != 0), rb);
    end
    end_frame(1'b1, AW'(2));
    // Hits during DRAIN/READOUT are dropped.
    hit_cycle(1'b1, AW'(2));
    hit_cycle(1'b1, AW'(2));
    wait_readout();

    // Frame 3: no hits, everything reads zero.
    start_frame(0);
    end_frame(1'b0, '0);
    wait_readout();

    // Frame 4: counter at the top of its range.
    ready_mode = 0;
    start_frame(0);
    poke_en = 1'b1; poke_addr = AW'(9); poke_data = DW'(MAXV - 1);
    tick();
    poke_en = 1'b0;
    hist[9] = MAXV - 1;
    repeat (3) hit_cycle(1'b1, AW'(9));
    hit_cycle(1'b1, AW'(20));
    end_frame(1'b1, AW'(9));
    wait_readout();

    // Frame 5: reset with an RMW write in flight, then a fresh frame.
    start_frame(0);
    for (int i = 0; i < 20; i++) hit_cycle(1'b1, AW'($urandom_range(0, 3)));
    hit_cycle(1'b1, AW'(4));
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    mdrop = 0;
    for (int i = 0; i < NB; i++) hist[i] = 0;
    check_reset_outputs();
    check("scoreboard_idle_after_reset", exp_q.size(), 0);
    ready_mode = 1;
    start_frame(0);
    for (int i = 0; i < 200; i++) hit_cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 5)));
    end_frame(1'b1, AW'(4));
    wait_readout();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/histo_ram_ctrl.md
Name: histo_ram_ctrl

Overview:
Sequences the 1024x24 dual-port histogram RAM (ram_dp) for one camera frame: clears all bins, accumulates bin hits from the pixel pipeline using read-modify-write, then streams bins out with a valid/ready handshake. Sits between the pixel binning logic and the readout/packetizer. Both RAM ports are driven from the single Clock domain.

Parameters:
ADDR_W, 10, bin address width; NUM_BINS = 2**ADDR_W
DATA_W, 24, bin counter width
RD_LAT, 1, RAM read latency in cycles, fixed at 1; other values are unsupported

Ports:
Clock  in  1  system clock; also drives RAM RdClock and WrClock
Reset  in  1  synchronous, active-high
start  in  1  pulse in IDLE: begin frame (CLEAR then ACCUM)
frame_end  in  1  pulse in ACCUM: stop accumulating, drain, then READOUT
hit_valid  in  1  bin hit strobe, one per cycle max
hit_bin  in  ADDR_W  bin index of hit
busy  out  1  high in any state other than IDLE
accum_ready  out  1  high only in ACCUM; hits outside ACCUM are dropped
dropped  out  16  saturating count of hits dropped while not ACCUM, cleared on start
out_valid  out  1  readout beat valid
out_ready  in  1  readout consumer ready
out_bin  out  ADDR_W  bin index of beat
out_data  out  DATA_W  bin count
out_last  out  1  marks bin NUM_BINS-1
ram_rd_addr  out  ADDR_W  to RdAddress
ram_rd_en  out  1  to RdClockEn
ram_q  in  DATA_W  from Q
ram_wr_addr  out  ADDR_W  to WrAddress
ram_wr_data  out  DATA_W  to Data
ram_we  out  1  to WE; WrClockEn is tied high at the top level; RAM Reset is tied to Reset

Behaviour:
- Reset: state=IDLE. All outputs 0 (busy, accum_ready, out_valid, out_last, ram_we, ram_rd_en, dropped, and all address/data buses).
- States: IDLE -> CLEAR on start. CLEAR writes 0 to addr 0..NUM_BINS-1, one address per cycle (NUM_BINS cycles), then -> ACCUM. ACCUM -> DRAIN on frame_end. DRAIN waits until the RMW pipeline is empty (at most 2 cycles), then -> READOUT. READOUT -> IDLE after the out_last beat is accepted.
- start outside IDLE and frame_end outside ACCUM are ignored.
- ACCUM RMW pipeline:
  - S0: a hit drives ram_rd_addr=hit_bin with ram_rd_en=1.
  - S1: ram_q is valid. Write ram_q+1 to the same address with ram_we=1.
  - A hit is sustained every cycle; there are no stalls.
- Hazard forwarding:
  - If the S1 address equals the address being written in the current cycle, the write-stage value is used instead of ram_q.
  - Also compare against the write issued in the previous cycle, so RAM write-to-read timing is covered.
  - Result: N back-to-back hits on one bin increment it by exactly N.
- Arithmetic: DATA_W-bit unsigned increment; behaviour at 2**DATA_W-1 is set by the optional feature.
- Hit during CLEAR, DRAIN, READOUT or IDLE: not written, and dropped increments (saturating at 0xFFFF). A hit in the same cycle as frame_end is accepted.
- READOUT:
  - Prefetch reads addr 0..NUM_BINS-1 into a 2-entry skid buffer; ram_rd_en is issued only when a slot is guaranteed.
  - out_* holds stable while out_valid && !out_ready.
  - Each accepted beat also writes 0 to that bin (clear-on-read).
  - out_bin is strictly ascending from 0, and out_last=1 only with out_bin=NUM_BINS-1.
- Reset mid-operation: returns to IDLE within one cycle; the in-flight RMW write is discarded and RAM contents are undefined until the next CLEAR.

Optional Feature:
HISTO_SAT_EN
- Defined: a bin at 2**DATA_W-1 stays at that value on further hits (saturates).
- Undefined: the bin wraps to 0.
- Forwarding logic is identical in both cases.

Decomposition:
- Package histo_pkg holds:
  - the HISTO_ADDR_W and HISTO_DATA_W constants;
  - the state enum (IDLE, CLEAR, ACCUM, DRAIN, READOUT);
  - NUM_BINS.
- One sub-module, histo_skid_buf: a 2-entry valid/ready buffer carrying {bin, data, last}, used by READOUT.

Test Plan:
- Reset, then start -> busy=1 for the whole CLEAR; exactly 1024 writes of 0 to addresses 0..1023, then accum_ready=1.
- Hits 5,5,5,5 back-to-back, then frame_end, out_ready=1 -> bin 5 reads 4 and all other bins read 0; 1024 beats, out_last on bin 1023.
- Alternating hits 7,8,7,8 (8 hits) and hits 3,3 separated by one idle cycle -> bins 7 and 8 read 4 each; bin 3 reads 2.
- READOUT with out_ready toggled randomly (including long low periods) -> no lost or duplicated beats, out_* stable while stalled; a second frame with no hits reads all zeros (clear-on-read).
- Force a bin to 0xFFFFFF via hits, then 2 more hits -> reads 0xFFFFFF with HISTO_SAT_EN defined, 0x000001 without it.
- 3 hits during CLEAR -> dropped=3, bins unaffected.
- Reset asserted mid-ACCUM with a write in flight, followed by a full frame -> the output matches the new frame only.
